// File: rtl/load_store_unit_pkg.sv
// Shared definitions for the load/store unit: FSM states, Store/Load
// encodings and the misalignment predicate used when
// LSU_MISALIGN_TRAP_EN is defined.
package load_store_unit_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } lsu_state_e;

  localparam logic [1:0] STORE_SB = 2'b00;
  localparam logic [1:0] STORE_SH = 2'b01;
  localparam logic [1:0] STORE_SW = 2'b10;

  localparam logic [2:0] LOAD_LB  = 3'b000;
  localparam logic [2:0] LOAD_LH  = 3'b001;
  localparam logic [2:0] LOAD_LW  = 3'b010;
  localparam logic [2:0] LOAD_LBU = 3'b100;
  localparam logic [2:0] LOAD_LHU = 3'b101;

  // Undefined Store/Load codes behave as word accesses, so they need word alignment.
  function automatic logic lsu_misaligned(input logic       is_store,
                                          input logic [1:0] store_op,
                                          input logic [2:0] load_op,
                                          input logic [1:0] addr_lo);
    logic mis;
    mis = 1'b0;
    if (is_store) begin
      case (store_op)
        STORE_SB: mis = 1'b0;
        STORE_SH: mis = addr_lo[0];
        STORE_SW: mis = |addr_lo;
        default:  mis = |addr_lo;
      endcase
    end else begin
      case (load_op)
        LOAD_LB, LOAD_LBU: mis = 1'b0;
        LOAD_LH, LOAD_LHU: mis = addr_lo[0];
        default:           mis = |addr_lo;
      endcase
    end
    return mis;
  endfunction

endpackage

// File: rtl/load_store_unit_lane_align.sv
// Byte-lane steering: store strobes / replicated write data, and
// load byte/half extraction with sign or zero extension.
module load_store_unit_lane_align
  import load_store_unit_pkg::*;
(
  input  logic [1:0]  store_op,
  input  logic [1:0]  st_addr_lo,
  input  logic [31:0] wd,
  input  logic [2:0]  load_op,
  input  logic [1:0]  ld_addr_lo,
  input  logic [31:0] rdata,
  output logic [3:0]  wstrb,
  output logic [31:0] wdata,
  output logic [31:0] load_data
);

  logic [31:0] byte_sh;
  logic [31:0] half_sh;

  // Store side: strobe shifted to the addressed lane, data replicated to every lane.
  always_comb begin
    wstrb = 4'b1111;
    wdata = wd;
    case (store_op)
      STORE_SB: begin
        wstrb = 4'b0001 << st_addr_lo;
        wdata = {4{wd[7:0]}};
      end
      STORE_SH: begin
        wstrb = 4'b0011 << {st_addr_lo[1], 1'b0};
        wdata = {2{wd[15:0]}};
      end
      default: begin
        wstrb = 4'b1111;
        wdata = wd;
      end
    endcase
  end

  // Load side: shift the addressed byte/half down to bit 0, then extend.
  always_comb begin
    byte_sh   = rdata >> {ld_addr_lo, 3'b000};
    half_sh   = rdata >> {ld_addr_lo[1], 4'b0000};
    load_data = rdata;
    case (load_op)
      LOAD_LB:  load_data = {{24{byte_sh[7]}}, byte_sh[7:0]};
      LOAD_LH:  load_data = {{16{half_sh[15]}}, half_sh[15:0]};
      LOAD_LBU: load_data = {24'd0, byte_sh[7:0]};
      LOAD_LHU: load_data = {16'd0, half_sh[15:0]};
      LOAD_LW:  load_data = rdata;
      default:  load_data = rdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: turns decoder MemRead/MemWrite controls into one
// req/ack data-memory transaction and stalls the core until it completes.
// Optional feature macro: LSU_MISALIGN_TRAP_EN (trap misaligned half/word
// accesses without touching the bus).
//
// Handshake: mem_req is registered and stays high, with all bus fields
// frozen, until a cycle in which mem_ack=1 is sampled; that cycle completes
// the transfer and mem_rdata is taken in the same cycle.
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int TIMEOUT_CYC = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [1:0]  Store,
  input  logic [2:0]  Load,
  input  logic [31:0] Addr,
  input  logic [31:0] WriteData,
  output logic        Stall,
  output logic [31:0] ReadData,
  output logic        BusErr,
  output logic        LsuMisalign,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic [1:0]  dbg_state
);

  localparam int TW = (TIMEOUT_CYC > 255) ? $clog2(TIMEOUT_CYC + 1) : 8;

  lsu_state_e  state, state_next;
  logic [TW-1:0] timer;
  logic [2:0]  ld_op_q;
  logic [1:0]  ld_addr_lo_q;
  logic        is_load_q;
  logic        access;
  logic        trap;
  logic        timeout_hit;
  logic [3:0]  lane_wstrb;
  logic [31:0] lane_wdata;
  logic [31:0] lane_load;

  assign access    = MemRead | MemWrite;
  assign dbg_state = state;

`ifdef LSU_MISALIGN_TRAP_EN
  assign trap = access && lsu_misaligned(MemWrite, Store, Load, Addr[1:0]);
`else
  assign trap = 1'b0;
`endif

  assign timeout_hit = (TIMEOUT_CYC != 0) && (timer == TW'(TIMEOUT_CYC - 1));

  load_store_unit_lane_align u_lane (
    .store_op   (Store),
    .st_addr_lo (Addr[1:0]),
    .wd         (WriteData),
    .load_op    (ld_op_q),
    .ld_addr_lo (ld_addr_lo_q),
    .rdata      (mem_rdata),
    .wstrb      (lane_wstrb),
    .wdata      (lane_wdata),
    .load_data  (lane_load)
  );

  // Next-state and combinational stall.
  always_comb begin
    state_next = state;
    Stall      = 1'b0;
    case (state)
      S_IDLE: begin
        if (access) begin
          Stall      = 1'b1;
          state_next = trap ? S_DONE : S_WAIT;
        end
      end
      S_WAIT: begin
        Stall = 1'b1;
        if (mem_ack || timeout_hit) state_next = S_DONE;
      end
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // State register, bus fields, timer and result/pulse registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_IDLE;
      mem_req      <= 1'b0;
      mem_we       <= 1'b0;
      mem_wstrb    <= 4'd0;
      mem_addr     <= 32'd0;
      mem_wdata    <= 32'd0;
      ReadData     <= 32'd0;
      BusErr       <= 1'b0;
      LsuMisalign  <= 1'b0;
      timer        <= '0;
      ld_op_q      <= 3'd0;
      ld_addr_lo_q <= 2'd0;
      is_load_q    <= 1'b0;
    end else begin
      state <= state_next;
      case (state)
        S_IDLE: begin
          BusErr      <= 1'b0;
          LsuMisalign <= 1'b0;
          ReadData    <= 32'd0;
          if (access) begin
            if (trap) begin
              LsuMisalign <= 1'b1;
            end else begin
              mem_req      <= 1'b1;
              mem_we       <= MemWrite;
              mem_addr     <= {Addr[31:2], 2'b00};
              mem_wstrb    <= MemWrite ? lane_wstrb : 4'd0;
              mem_wdata    <= MemWrite ? lane_wdata : 32'd0;
              timer        <= '0;
              ld_op_q      <= Load;
              ld_addr_lo_q <= Addr[1:0];
              is_load_q    <= ~MemWrite;
            end
          end
        end
        S_WAIT: begin
          if (mem_ack) begin
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_wstrb <= 4'd0;
            ReadData  <= is_load_q ? lane_load : 32'd0;
          end else if (timeout_hit) begin
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_wstrb <= 4'd0;
            BusErr    <= 1'b1;
            ReadData  <= 32'd0;
          end else if (timer != '1) begin
            timer <= timer + 1'b1;
          end
        end
        default: begin
          BusErr      <= 1'b0;
          LsuMisalign <= 1'b0;
          ReadData    <= 32'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit (TIMEOUT_CYC=4). Honors LSU_MISALIGN_TRAP_EN.
module tb_load_store_unit;

  localparam int TMO = 4;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic        clk = 1'b0;
  logic        reset;
  logic        MemRead, MemWrite;
  logic [1:0]  Store;
  logic [2:0]  Load;
  logic [31:0] Addr, WriteData;
  logic        Stall;
  logic [31:0] ReadData;
  logic        BusErr, LsuMisalign;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic [1:0]  dbg_state;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] exp_q[$];

  load_store_unit #(.TIMEOUT_CYC(TMO)) dut (
    .clk(clk), .reset(reset), .MemRead(MemRead), .MemWrite(MemWrite),
    .Store(Store), .Load(Load), .Addr(Addr), .WriteData(WriteData),
    .Stall(Stall), .ReadData(ReadData), .BusErr(BusErr), .LsuMisalign(LsuMisalign),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_ack(mem_ack), .mem_rdata(mem_rdata), .dbg_state(dbg_state)
  );

  // clock / watchdog
  always #5 clk = ~clk;
  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // reference model
  function automatic logic [31:0] model_load(input logic [2:0] ld, input logic [1:0] a,
                                             input logic [31:0] rd);
    logic [7:0]  b;
    logic [15:0] h;
    case (a)
      2'd0: b = rd[7:0];
      2'd1: b = rd[15:8];
      2'd2: b = rd[23:16];
      default: b = rd[31:24];
    endcase
    h = a[1] ? rd[31:16] : rd[15:0];
    case (ld)
      3'b000: return b[7] ? {24'hFFFFFF, b} : {24'h0, b};
      3'b001: return h[15] ? {16'hFFFF, h} : {16'h0, h};
      3'b100: return {24'h0, b};
      3'b101: return {16'h0, h};
      default: return rd;
    endcase
  endfunction

  function automatic logic [3:0] model_strb(input logic [1:0] st, input logic [1:0] a);
    if (st == 2'b00) begin
      case (a)
        2'd0: return 4'b0001;
        2'd1: return 4'b0010;
        2'd2: return 4'b0100;
        default: return 4'b1000;
      endcase
    end else if (st == 2'b01) begin
      return a[1] ? 4'b1100 : 4'b0011;
    end
    return 4'b1111;
  endfunction

  function automatic logic [31:0] model_wdata(input logic [1:0] st, input logic [31:0] wd);
    if (st == 2'b00) return {wd[7:0], wd[7:0], wd[7:0], wd[7:0]};
    if (st == 2'b01) return {wd[15:0], wd[15:0]};
    return wd;
  endfunction

  function automatic bit model_trap(input logic wr, input logic [1:0] st, input logic [2:0] ld,
                                    input logic [1:0] a);
    bit t;
    t = 0;
`ifdef LSU_MISALIGN_TRAP_EN
    if (wr) t = (st == 2'b00) ? 1'b0 : (st == 2'b01) ? a[0] : (a != 2'd0);
    else if (ld == 3'b000 || ld == 3'b100) t = 0;
    else if (ld == 3'b001 || ld == 3'b101) t = a[0];
    else t = (a != 2'd0);
`endif
    return t;
  endfunction

  // driver: starts on a negedge with DUT in IDLE, returns on the negedge after DONE
  task automatic run_access(input string nm, input logic rd, input logic wr, input logic [1:0] st,
                            input logic [2:0] ld, input logic [31:0] a, input logic [31:0] wd,
                            input int ack_dly, input logic [31:0] rdat, input bit do_ack);
    bit   trap;
    int   cnt;
    logic [31:0] exp_rd;
    trap = (rd | wr) && model_trap(wr, st, ld, a[1:0]);
    MemRead = rd; MemWrite = wr; Store = st; Load = ld; Addr = a; WriteData = wd;
    #1;
    check_eq({nm, ":stall_issue"}, 32'(Stall), 32'd1);
    check_eq({nm, ":state_issue"}, 32'(dbg_state), 32'(ST_IDLE));
    if (trap || wr || !do_ack) exp_rd = 32'd0;
    else exp_rd = model_load(ld, a[1:0], rdat);
    exp_q.push_back(exp_rd);
    @(negedge clk);
    if (trap) begin
      check_eq({nm, ":trap_req"}, 32'(mem_req), 32'd0);
      check_eq({nm, ":trap_flag"}, 32'(LsuMisalign), 32'd1);
    end else begin
      check_eq({nm, ":req"}, 32'(mem_req), 32'd1);
      check_eq({nm, ":we"}, 32'(mem_we), 32'(wr));
      check_eq({nm, ":addr"}, mem_addr, {a[31:2], 2'b00});
      check_eq({nm, ":wstrb"}, 32'(mem_wstrb), wr ? 32'(model_strb(st, a[1:0])) : 32'd0);
      if (wr) check_eq({nm, ":wdata"}, mem_wdata, model_wdata(st, wd));
      if (do_ack) begin
        for (int i = 0; i < ack_dly; i++) begin
          check_eq({nm, ":hold_req"}, 32'(mem_req & Stall), 32'd1);
          @(negedge clk);
        end
        mem_ack = 1'b1; mem_rdata = rdat;
        @(negedge clk);
        mem_ack = 1'b0; mem_rdata = $urandom;
      end else begin
        cnt = 0;
        while (dbg_state != ST_DONE && cnt < 20) begin
          if (mem_req) cnt++;
          @(negedge clk);
        end
        check_eq({nm, ":tmo_cycles"}, cnt, TMO);
      end
      check_eq({nm, ":misalign"}, 32'(LsuMisalign), 32'd0);
    end
    check_eq({nm, ":done_state"}, 32'(dbg_state), 32'(ST_DONE));
    check_eq({nm, ":done_stall"}, 32'(Stall), 32'd0);
    check_eq({nm, ":done_req"}, 32'(mem_req), 32'd0);
    check_eq({nm, ":buserr"}, 32'(BusErr), 32'((!trap && !do_ack) ? 1 : 0));
    if (exp_q.size() == 0) check_eq({nm, ":sb_empty"}, 32'd0, 32'd1);
    else check_eq({nm, ":rdata"}, ReadData, exp_q.pop_front());
    MemRead = 1'b0; MemWrite = 1'b0;
    @(negedge clk);
    check_eq({nm, ":idle_after"}, 32'(dbg_state), 32'(ST_IDLE));
    check_eq({nm, ":pulse_clr"}, 32'(BusErr | LsuMisalign), 32'd0);
  endtask

  initial begin
    reset = 1'b1; MemRead = 0; MemWrite = 0; Store = 0; Load = 0; Addr = 0; WriteData = 0;
    mem_ack = 0; mem_rdata = 0;
    repeat (3) @(negedge clk);
    // reset state
    check_eq("rst_state", 32'(dbg_state), 32'(ST_IDLE));
    check_eq("rst_req", 32'(mem_req | mem_we | BusErr | LsuMisalign | Stall), 32'd0);
    check_eq("rst_wstrb", 32'(mem_wstrb), 32'd0);
    check_eq("rst_addr", mem_addr, 32'd0);
    check_eq("rst_wdata", mem_wdata, 32'd0);
    check_eq("rst_rdata", ReadData, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // directed cases
    run_access("sb",  1'b0, 1'b1, 2'b00, 3'b000, 32'h1003, 32'h000000A5, 2, 32'h0, 1);
    run_access("lb",  1'b1, 1'b0, 2'b00, 3'b000, 32'h2002, 32'h0, 0, 32'h0080FF00, 1);
    run_access("lbu", 1'b1, 1'b0, 2'b00, 3'b100, 32'h2002, 32'h0, 1, 32'h0080FF00, 1);
    run_access("lhu", 1'b1, 1'b0, 2'b00, 3'b101, 32'h2002, 32'h0, 0, 32'h0080FF00, 1);
    run_access("lh",  1'b1, 1'b0, 2'b00, 3'b001, 32'h2000, 32'h0, 0, 32'h1234F00D, 1);
    run_access("lw_tmo", 1'b1, 1'b0, 2'b00, 3'b010, 32'h4000, 32'h0, 0, 32'h0, 0);
    run_access("sh_mis", 1'b0, 1'b1, 2'b01, 3'b000, 32'h3001, 32'h0000BEEF, 0, 32'h0, 1);
    run_access("both_st", 1'b1, 1'b1, 2'b11, 3'b010, 32'h5004, 32'hCAFEF00D, 0, 32'h11111111, 1);
    // back-to-back sw then lw: the IDLE cycle between them is checked by the task
    run_access("b2b_sw", 1'b0, 1'b1, 2'b10, 3'b000, 32'h6000, 32'hDEADBEEF, 0, 32'h0, 1);
    run_access("b2b_lw", 1'b1, 1'b0, 2'b00, 3'b010, 32'h6000, 32'h0, 0, 32'h87654321, 1);

    // reset during WAIT, then a late ack
    MemRead = 1'b1; Load = 3'b010; Addr = 32'h7000;
    @(negedge clk);
    check_eq("rstw_req", 32'(mem_req), 32'd1);
    reset = 1'b1; MemRead = 1'b0;
    @(negedge clk);
    reset = 1'b0; mem_ack = 1'b1; mem_rdata = 32'hFFFFFFFF;
    check_eq("rstw_state", 32'(dbg_state), 32'(ST_IDLE));
    check_eq("rstw_req0", 32'(mem_req), 32'd0);
    check_eq("rstw_stall", 32'(Stall), 32'd0);
    @(negedge clk);
    mem_ack = 1'b0;
    check_eq("rstw_nodone", 32'(dbg_state), 32'(ST_IDLE));
    check_eq("rstw_noerr", 32'(BusErr), 32'd0);
    check_eq("rstw_req1", 32'(mem_req), 32'd0);

    // random traffic
    for (int k = 0; k < 25; k++) begin
      int op;
      op = $urandom_range(0, 2);
      run_access("rnd", (op != 1), (op != 0), 2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)),
                 32'($urandom), 32'($urandom), $urandom_range(0, 3), 32'($urandom),
                 ($urandom_range(0, 5) != 0));
    end

    check_eq("sb_drained", exp_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
